mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multicycle control sequencer for the MIPS CPU datapath. It steps each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath select and write enable, including the immediate-extension mode (sign vs zero) used by the sign-extend unit. It stalls on a memory ready handshake, flags unsupported opcodes and counts retired instructions.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  6  opcode field (instruction register bits 31:26)
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pcwrite  out  1  unconditional PC write
- branch  out  1  PC write qualified by zero (beq)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memread  out  1  memory read request
- memwrite  out  1  memory write request
- irwrite  out  1  instruction register load
- regdst  out  1  destination register: 0 = rt, 1 = rd
- memtoreg  out  1  write-back source: 0 = ALUOut, 1 = MDR
- regwrite  out  1  register file write
- alusrca  out  1  ALU A: 0 = PC, 1 = rs register
- alusrcb  out  2  ALU B: 00 = rt, 01 = constant 4, 10 = extended immediate, 11 = extended immediate << 2
- aluop  out  2  00 = add, 01 = sub, 10 = funct decode, 11 = logic op from opcode
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- extop  out  1  1 = sign-extend the immediate, 0 = zero-extend it
- illegal  out  1  one-cycle pulse when an unsupported opcode is decoded
- instret  out  32  count of retired instructions

## Operation
- Moore FSM. States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, BEQEX, IEX, IWB, JEX.
- Outputs not listed for a state are 0. Exceptions: extop = 1 and alusrcb = 11 in DECODE.
- FETCH
  - Outputs: memread = 1, iord = 0, alusrca = 0, alusrcb = 01, aluop = 00, pcsrc = 00.
  - irwrite = pcwrite = mem_ready.
  - Stays in FETCH until mem_ready = 1, then goes to DECODE.
- DECODE
  - Outputs: alusrca = 0, alusrcb = 11, aluop = 00, extop = 1 (branch target precompute).
  - Next state by op:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 -> REX
    - 000100 -> BEQEX
    - 001000 (addi), 001100 (andi), 001101 (ori) -> IEX
    - 000010 -> JEX
    - any other op -> FETCH, with illegal = 1 for this cycle and instret unchanged
- MEMADR
  - Outputs: alusrca = 1, alusrcb = 10, aluop = 00, extop = 1.
  - Next: lw -> MEMRD; sw -> MEMWR.
- MEMRD: memread = 1, iord = 1. Waits for mem_ready, then -> MEMWB.
- MEMWB: regwrite = 1, memtoreg = 1, regdst = 0. -> FETCH.
- MEMWR: memwrite = 1, iord = 1. Waits for mem_ready, then -> FETCH.
- REX: alusrca = 1, alusrcb = 00, aluop = 10. -> RWB.
- RWB: regwrite = 1, regdst = 1, memtoreg = 0. -> FETCH.
- BEQEX: alusrca = 1, alusrcb = 00, aluop = 01, branch = 1, pcsrc = 01. -> FETCH.
- IEX
  - Outputs: alusrca = 1, alusrcb = 10.
  - extop = 1 and aluop = 00 for addi; extop = 0 and aluop = 11 for andi/ori.
  - -> IWB.
- IWB
  - Outputs: regwrite = 1, regdst = 0, memtoreg = 0.
  - extop holds the IEX value so the immediate path stays stable.
  - -> FETCH.
- JEX: pcwrite = 1, pcsrc = 10. -> FETCH.
- op is sampled combinationally. The instruction register holds op stable from DECODE until the next FETCH completes.
- instret
  - Increments by 1 on the clock edge leaving MEMWB, MEMWR (with mem_ready), RWB, BEQEX, IWB or JEX.
  - Wraps from 0xFFFFFFFF to 0.
  - Never increments on an illegal opcode.

## Timing
- Reset
  - While rst_n = 0: state = FETCH, instret = 0.
  - All outputs are forced to 0 combinationally while rst_n = 0, including memread, irwrite and pcwrite.
  - FETCH outputs take effect in the first cycle after rst_n deasserts.
  - Reset asserted mid-instruction aborts it immediately, with no retire count.
- Cycles per instruction with mem_ready always 1:
  - lw 5, sw 4, R-type 4, addi/andi/ori 4, beq 3, j 3.
  - Each wait cycle in FETCH, MEMRD or MEMWR adds one cycle.
- illegal and instret changes are cycle-accurate: illegal is high exactly during the DECODE cycle of the bad opcode.
- mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles with mem_ready = 1 -> all outputs 0, instret = 0. Release -> first cycle shows memread = 1 and irwrite = 1.
- lw, then sw, zero wait: op = 100011 then 101011 -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, then FETCH, DECODE, MEMADR, MEMWR. regwrite = 1 only in the MEMWB cycle. instret = 2 after 9 cycles.
- Stalls: mem_ready low for 2 cycles in FETCH and 3 cycles in MEMRD -> irwrite/pcwrite pulse only in the ready cycle. lw completes in 10 cycles.
- Extension modes:
  - addi (001000) -> extop = 1 in IEX and IWB.
  - ori (001101) -> extop = 0 and aluop = 11 in IEX, extop = 0 in IWB.
  - DECODE always has extop = 1.
- beq and j: beq takes 3 cycles with branch = 1 and pcsrc = 01 in BEQEX. j takes 3 cycles with pcwrite = 1 and pcsrc = 10 in JEX.
- Illegal opcode and wrap:
  - op = 111111 -> illegal high for 1 cycle, then FETCH, instret unchanged.
  - Preload instret to 0xFFFFFFFF, run one R-type -> instret = 0.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multicycle sequencer and the MIPS datapath.
// master: sequencer side (drives selects/enables, sees op, zero, mem_ready).
// slave: datapath side (drives op, zero, mem_ready, consumes selects and pc_en).
interface mc_ctrl_if;
  logic [5:0]  op;
  logic        zero;
  logic        mem_ready;
  logic        pcwrite;
  logic        branch;
  logic        iord;
  logic        memread;
  logic        memwrite;
  logic        irwrite;
  logic        regdst;
  logic        memtoreg;
  logic        regwrite;
  logic        alusrca;
  logic [1:0]  alusrcb;
  logic [1:0]  aluop;
  logic [1:0]  pcsrc;
  logic        extop;
  logic        illegal;
  logic [31:0] instret;
  logic        pc_en;

  // PC load enable as seen by the PC register: unconditional write, or a
  // beq whose comparison came out equal.
  assign pc_en = pcwrite | (branch & zero);

  modport master (
    input  op, zero, mem_ready,
    output pcwrite, branch, iord, memread, memwrite, irwrite, regdst,
           memtoreg, regwrite, alusrca, alusrcb, aluop, pcsrc, extop,
           illegal, instret
  );

  modport slave (
    output op, zero, mem_ready,
    input  pcwrite, branch, iord, memread, memwrite, irwrite, regdst,
           memtoreg, regwrite, alusrca, alusrcb, aluop, pcsrc, extop,
           illegal, instret, pc_en
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control sequencer (Moore FSM, FETCH..JEX).
// Ports: clk, rst_n (async active-low), bus (mc_ctrl_if.master: op, zero,
// mem_ready in; datapath selects/enables, illegal pulse, instret count out).
// Stalls in FETCH/MEMRD/MEMWR until mem_ready; outputs are zero during reset.
module mc_ctrl (
  input  logic      clk,
  input  logic      rst_n,
  mc_ctrl_if.master bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    REX, RWB, BEQEX, IEX, IWB, JEX
  } state_t;

  state_t      state, nxt;
  logic [31:0] instret_q;
  logic        retire;

  logic        pcwrite, branch, iord, memread, memwrite, irwrite;
  logic        regdst, memtoreg, regwrite, alusrca, extop, illegal;
  logic [1:0]  alusrcb, aluop, pcsrc;
  logic [17:0] ctl;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      FETCH:  if (bus.mem_ready) nxt = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW:             nxt = MEMADR;
          OP_RTYPE:                 nxt = REX;
          OP_BEQ:                   nxt = BEQEX;
          OP_ADDI, OP_ANDI, OP_ORI: nxt = IEX;
          OP_J:                     nxt = JEX;
          default:                  nxt = FETCH;
        endcase
      end
      MEMADR: nxt = (bus.op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (bus.mem_ready) nxt = MEMWB;
      MEMWB:  nxt = FETCH;
      MEMWR:  if (bus.mem_ready) nxt = FETCH;
      REX:    nxt = RWB;
      RWB:    nxt = FETCH;
      BEQEX:  nxt = FETCH;
      IEX:    nxt = IWB;
      IWB:    nxt = FETCH;
      JEX:    nxt = FETCH;
      default: nxt = FETCH;
    endcase
  end

  // Output logic
  always_comb begin
    pcwrite  = 1'b0; branch   = 1'b0; iord     = 1'b0; memread  = 1'b0;
    memwrite = 1'b0; irwrite  = 1'b0; regdst   = 1'b0; memtoreg = 1'b0;
    regwrite = 1'b0; alusrca  = 1'b0; extop    = 1'b0; illegal  = 1'b0;
    alusrcb  = 2'b00; aluop   = 2'b00; pcsrc   = 2'b00;
    retire   = 1'b0;
    case (state)
      FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = bus.mem_ready;
        pcwrite = bus.mem_ready;
      end
      DECODE: begin
        // Branch target precompute: PC + (sign-extended imm << 2)
        alusrcb = 2'b11;
        extop   = 1'b1;
        case (bus.op)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_J: ;
          default: illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        extop   = 1'b1;
      end
      MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        retire   = 1'b1;
      end
      MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        retire   = bus.mem_ready;
      end
      REX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        retire   = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        branch  = 1'b1;
        pcsrc   = 2'b01;
        retire  = 1'b1;
      end
      IEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        extop   = (bus.op == OP_ADDI);
        aluop   = (bus.op == OP_ADDI) ? 2'b00 : 2'b11;
      end
      IWB: begin
        regwrite = 1'b1;
        // op is still held by the IR, so extop matches the IEX cycle
        extop    = (bus.op == OP_ADDI);
        retire   = 1'b1;
      end
      JEX: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
        retire  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret_q <= 32'd0;
    else if (retire) instret_q <= instret_q + 32'd1;
  end

  // Everything is forced low while reset is held, independent of state.
  assign ctl = {pcwrite, branch, iord, memread, memwrite, irwrite,
                regdst, memtoreg, regwrite, alusrca, alusrcb, aluop,
                pcsrc, extop, illegal};

  assign {bus.pcwrite, bus.branch, bus.iord, bus.memread, bus.memwrite,
          bus.irwrite, bus.regdst, bus.memtoreg, bus.regwrite, bus.alusrca,
          bus.alusrcb, bus.aluop, bus.pcsrc, bus.extop, bus.illegal}
         = rst_n ? ctl : 18'd0;

  assign bus.instret = rst_n ? instret_q : 32'd0;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed testbench for mc_ctrl: walks each instruction class cycle by
// cycle and compares the full control word against hand-built constants.
module tb_mc_ctrl;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  mc_ctrl_if bus();

  mc_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] obs;
  assign obs = {bus.pcwrite, bus.branch, bus.iord, bus.memread, bus.memwrite,
                bus.irwrite, bus.regdst, bus.memtoreg, bus.regwrite,
                bus.alusrca, bus.alusrcb, bus.aluop, bus.pcsrc, bus.extop,
                bus.illegal};

  // pcw br iord mr mw ir _ rd mt rw _ a _ b _ aluop _ pcsrc _ ext _ ill
  localparam logic [17:0] W_FR   = 18'b100101_000_0_01_00_00_0_0;
  localparam logic [17:0] W_FW   = 18'b000100_000_0_01_00_00_0_0;
  localparam logic [17:0] W_DEC  = 18'b000000_000_0_11_00_00_1_0;
  localparam logic [17:0] W_DILL = 18'b000000_000_0_11_00_00_1_1;
  localparam logic [17:0] W_MADR = 18'b000000_000_1_10_00_00_1_0;
  localparam logic [17:0] W_MRD  = 18'b001100_000_0_00_00_00_0_0;
  localparam logic [17:0] W_MWB  = 18'b000000_011_0_00_00_00_0_0;
  localparam logic [17:0] W_MWR  = 18'b001010_000_0_00_00_00_0_0;
  localparam logic [17:0] W_REX  = 18'b000000_000_1_00_10_00_0_0;
  localparam logic [17:0] W_RWB  = 18'b000000_101_0_00_00_00_0_0;
  localparam logic [17:0] W_BEQ  = 18'b010000_000_1_00_01_01_0_0;
  localparam logic [17:0] W_IEXA = 18'b000000_000_1_10_00_00_1_0;
  localparam logic [17:0] W_IEXO = 18'b000000_000_1_10_11_00_0_0;
  localparam logic [17:0] W_IWBA = 18'b000000_001_0_00_00_00_1_0;
  localparam logic [17:0] W_IWBO = 18'b000000_001_0_00_00_00_0_0;
  localparam logic [17:0] W_JEX  = 18'b100000_000_0_00_00_10_0_0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000, ORI = 6'b001101;

  // Leaves the DUT in the first FETCH cycle, 1ns after a rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.mem_ready = 1'b1; bus.op = RT; bus.zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 18'd0) begin
        errors++; $display("FAIL reset_ctl cyc%0d got %b want 0", i, obs);
      end
      checks++;
      if (bus.instret !== 32'd0) begin
        errors++; $display("FAIL reset_instret got %0d want 0", bus.instret);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== W_FR) begin
      errors++; $display("FAIL reset_first_fetch got %b want %b", obs, W_FR);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lw_sw();
    logic [17:0] ew [9] = '{W_FR, W_DEC, W_MADR, W_MRD, W_MWB,
                            W_FR, W_DEC, W_MADR, W_MWR};
    do_reset();
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.op = (i < 5) ? LW : SW;
      @(negedge clk);
      checks++;
      if (obs !== ew[i]) begin
        errors++; $display("FAIL lw_sw cyc%0d got %b want %b", i, obs, ew[i]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bus.instret !== 32'd2) begin
      errors++; $display("FAIL lw_sw_instret got %0d want 2", bus.instret);
    end
  endtask

  task automatic test_stall();
    logic [17:0] ew [10] = '{W_FW, W_FW, W_FR, W_DEC, W_MADR,
                             W_MRD, W_MRD, W_MRD, W_MRD, W_MWB};
    // mem_ready low in DECODE/MEMADR/MEMWB must have no effect
    logic        mr [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                             1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    bus.op = LW;
    for (int i = 0; i < 10; i++) begin
      bus.mem_ready = mr[i];
      @(negedge clk);
      checks++;
      if (obs !== ew[i]) begin
        errors++; $display("FAIL stall cyc%0d got %b want %b", i, obs, ew[i]);
      end
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b1;
    checks++;
    if (bus.instret !== 32'd1) begin
      errors++; $display("FAIL stall_instret got %0d want 1", bus.instret);
    end
  endtask

  task automatic test_ext_modes();
    logic [17:0] ew [8] = '{W_FR, W_DEC, W_IEXA, W_IWBA,
                            W_FR, W_DEC, W_IEXO, W_IWBO};
    do_reset();
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.op = (i < 4) ? ADDI : ORI;
      @(negedge clk);
      checks++;
      if (obs !== ew[i]) begin
        errors++; $display("FAIL ext cyc%0d got %b want %b", i, obs, ew[i]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bus.instret !== 32'd2) begin
      errors++; $display("FAIL ext_instret got %0d want 2", bus.instret);
    end
  endtask

  task automatic test_beq_j();
    logic [17:0] ew [6] = '{W_FR, W_DEC, W_BEQ, W_FR, W_DEC, W_JEX};
    do_reset();
    bus.mem_ready = 1'b1;
    bus.zero = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.op = (i < 3) ? BEQ : J;
      @(negedge clk);
      checks++;
      if (obs !== ew[i]) begin
        errors++; $display("FAIL beq_j cyc%0d got %b want %b", i, obs, ew[i]);
      end
      if (i == 2) begin
        checks++;
        if (bus.pc_en !== 1'b1) begin
          errors++; $display("FAIL beq_pc_en got %b want 1", bus.pc_en);
        end
      end
      @(posedge clk); #1;
    end
    bus.zero = 1'b0;
    checks++;
    if (bus.instret !== 32'd2) begin
      errors++; $display("FAIL beq_j_instret got %0d want 2", bus.instret);
    end
  endtask

  task automatic test_illegal();
    logic [17:0] ew [4] = '{W_FR, W_DILL, W_FR, W_DEC};
    do_reset();
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.op = (i < 2) ? 6'b111111 : RT;
      @(negedge clk);
      checks++;
      if (obs !== ew[i]) begin
        errors++; $display("FAIL illegal cyc%0d got %b want %b", i, obs, ew[i]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bus.instret !== 32'd0) begin
      errors++; $display("FAIL illegal_instret got %0d want 0", bus.instret);
    end
  endtask

  task automatic test_wrap();
    logic [17:0] ew [4] = '{W_FW, W_FR, W_DEC, W_REX};
    do_reset();
    bus.op = RT;
    force dut.instret_q = 32'hFFFF_FFFF;
    bus.mem_ready = 1'b0;
    #2;
    release dut.instret_q;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = (i != 0);
      @(negedge clk);
      checks++;
      if (obs !== ew[i]) begin
        errors++; $display("FAIL wrap cyc%0d got %b want %b", i, obs, ew[i]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bus.instret !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL wrap_preload got %h want ffffffff", bus.instret);
    end
    @(negedge clk);
    checks++;
    if (obs !== W_RWB) begin
      errors++; $display("FAIL wrap_rwb got %b want %b", obs, W_RWB);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.instret !== 32'd0) begin
      errors++; $display("FAIL wrap_instret got %h want 0", bus.instret);
    end
  endtask

  task automatic test_abort();
    do_reset();
    bus.mem_ready = 1'b1;
    bus.op = RT;
    repeat (3) begin @(posedge clk); #1; end  // now in RWB
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 18'd0 || bus.instret !== 32'd0) begin
      errors++;
      $display("FAIL abort_reset got %b/%0d want 0/0", obs, bus.instret);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== W_FR || bus.instret !== 32'd0) begin
      errors++;
      $display("FAIL abort_fetch got %b/%0d want %b/0", obs, bus.instret, W_FR);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.op = RT; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    test_reset();
    test_lw_sw();
    test_stall();
    test_ext_modes();
    test_beq_j();
    test_illegal();
    test_wrap();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
